// File: rtl/pool2d_stream.sv
// Streaming POOL x POOL pooling (max or average) over CH parallel channels.
// Horizontal partials live in a per-channel accumulator; vertical partials live
// in a per-window-column line buffer, so in_valid gaps never lose window state.
module pool2d_stream #(
  parameter int unsigned dataColNum = 28,
  parameter int unsigned dataRowNum = 28,
  parameter int unsigned wordlength = 16,
  parameter int unsigned CH         = 4,
  parameter int unsigned POOL       = 2
) (
  input  logic                       clk,
  input  logic                       irst_n,
  input  logic                       in_valid,
  input  logic                       mode,
  input  logic [CH*wordlength-1:0]   pixels_in,
  output logic [CH*wordlength-1:0]   data_out,
  output logic                       out_valid,
  output logic                       frame_done
);

  localparam int unsigned LOG2P = $clog2(POOL);
  localparam int unsigned ACC   = wordlength + 2 * LOG2P;
  localparam int unsigned WC    = dataColNum / POOL;
  localparam int unsigned WR    = dataRowNum / POOL;
  localparam int unsigned CUSED = WC * POOL;
  localparam int unsigned RUSED = WR * POOL;
  localparam int unsigned CW    = (dataColNum > 1) ? $clog2(dataColNum) : 1;
  localparam int unsigned RW    = (dataRowNum > 1) ? $clog2(dataRowNum) : 1;
  localparam int unsigned WCW   = (WC > 1) ? $clog2(WC) : 1;

  typedef logic signed [ACC-1:0] acc_t;

  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      mode_q, mode_d;
  acc_t                      hacc_q [CH];
  acc_t                      hacc_d [CH];
  acc_t                      lb_q [WC][CH];
  acc_t                      lb_wdata [CH];
  logic                      lb_we;
  logic [WCW-1:0]            wc;
  logic [CH*wordlength-1:0]  data_out_d;
  logic                      out_valid_d, frame_done_d;

  logic                      first_px, avg, in_win, first_col, last_col;
  logic [LOG2P-1:0]          col_off, row_off;
  logic signed [wordlength-1:0] pxn;
  acc_t                      pxe, h, res, sh;

  // Max or sum of two partial results, depending on the frame's mode.
  function automatic acc_t combine(input acc_t a, input acc_t b, input logic is_avg);
    if (is_avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  // Next-state: counters, mode capture, accumulators, line-buffer write, output.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    mode_d       = mode_q;
    hacc_d       = hacc_q;
    lb_we        = 1'b0;
    for (int c = 0; c < CH; c++) lb_wdata[c] = '0;
    data_out_d   = data_out;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    pxn          = '0;
    pxe          = '0;
    h            = '0;
    res          = '0;
    sh           = '0;

    first_px  = (col_q == '0) && (row_q == '0);
    avg       = first_px ? mode : mode_q;
    wc        = WCW'(col_q >> LOG2P);
    in_win    = (32'(col_q) < CUSED) && (32'(row_q) < RUSED);
    col_off   = col_q[LOG2P-1:0];
    row_off   = row_q[LOG2P-1:0];
    first_col = (col_off == '0);
    last_col  = (col_off == LOG2P'(POOL - 1));

    if (in_valid) begin
      if (first_px) mode_d = mode;

      if (col_q == CW'(dataColNum - 1)) begin
        col_d = '0;
        if (row_q == RW'(dataRowNum - 1)) row_d = '0;
        else                              row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      if (in_win) begin
        for (int c = 0; c < CH; c++) begin
          pxn = pixels_in[c*wordlength +: wordlength];
          pxe = ACC'(pxn);
          if (first_col) hacc_d[c] = pxe;
          else           hacc_d[c] = combine(hacc_q[c], pxe, avg);
          h = combine(hacc_q[c], pxe, avg);
          if (last_col) begin
            if (row_off == '0) begin
              lb_we       = 1'b1;
              lb_wdata[c] = h;
            end else if (row_off != LOG2P'(POOL - 1)) begin
              lb_we       = 1'b1;
              lb_wdata[c] = combine(lb_q[wc][c], h, avg);
            end else begin
              res = combine(lb_q[wc][c], h, avg);
              sh  = avg ? (res >>> (2 * LOG2P)) : res;
              data_out_d[c*wordlength +: wordlength] = sh[wordlength-1:0];
            end
          end
        end
        if (last_col && (row_off == LOG2P'(POOL - 1))) begin
          out_valid_d  = 1'b1;
          frame_done_d = (32'(row_q >> LOG2P) == WR - 1) && (32'(col_q >> LOG2P) == WC - 1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= 1'b0;
      for (int c = 0; c < CH; c++) hacc_q[c] <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      mode_q     <= mode_d;
      for (int c = 0; c < CH; c++) hacc_q[c] <= hacc_d[c];
      data_out   <= data_out_d;
      out_valid  <= out_valid_d;
      frame_done <= frame_done_d;
    end
  end

  // Line buffer: vertical partials per window column, always written before read.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      for (int c = 0; c < CH; c++) lb_q[wc][c] <= lb_wdata[c];
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Bench for pool2d_stream: three configurations, directed and random frames,
// checked every cycle against a window-level reference model.
module tb_pool2d_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a: 4x4, CH=4, W=16, POOL=2
  logic        val_a, mode_a;
  logic [63:0] pix_a, dout_a;
  logic        ov_a, fd_a;
  // Instance b: 5x5, CH=1, W=16, POOL=2 (partial row/column)
  logic        val_b, mode_b;
  logic [15:0] pix_b, dout_b;
  logic        ov_b, fd_b;
  // Instance c: 10x9, CH=2, W=8, POOL=4 (middle-row line-buffer path)
  logic        val_c, mode_c;
  logic [15:0] pix_c, dout_c;
  logic        ov_c, fd_c;

  pool2d_stream #(.dataColNum(4), .dataRowNum(4), .wordlength(16), .CH(4), .POOL(2)) u_a (
    .clk(clk), .irst_n(rst_n), .in_valid(val_a), .mode(mode_a), .pixels_in(pix_a),
    .data_out(dout_a), .out_valid(ov_a), .frame_done(fd_a));
  pool2d_stream #(.dataColNum(5), .dataRowNum(5), .wordlength(16), .CH(1), .POOL(2)) u_b (
    .clk(clk), .irst_n(rst_n), .in_valid(val_b), .mode(mode_b), .pixels_in(pix_b),
    .data_out(dout_b), .out_valid(ov_b), .frame_done(fd_b));
  pool2d_stream #(.dataColNum(10), .dataRowNum(9), .wordlength(8), .CH(2), .POOL(4)) u_c (
    .clk(clk), .irst_n(rst_n), .in_valid(val_c), .mode(mode_c), .pixels_in(pix_c),
    .data_out(dout_c), .out_valid(ov_c), .frame_done(fd_c));

  int NC [3] = '{4, 5, 10};
  int NR [3] = '{4, 5, 9};
  int PP [3] = '{2, 2, 4};
  int NCH[3] = '{4, 1, 2};
  int WW [3] = '{16, 16, 8};

  int fr [10][10][4];
  int last_d [3][4];
  int obs_v, obs_fd;
  int obs_d [4];
  int n_vec = 0;
  int n_err = 0;

  function automatic int sx(input int v, input int w);
    int m;
    m = v & ((1 << w) - 1);
    if (m >= (1 << (w - 1))) m -= (1 << w);
    return m;
  endfunction

  // Reference: pooled value of the window whose top-left pixel is (r0,c0).
  function automatic int win_exp(input int dut, input int r0, input int c0, input int ch, input bit md);
    int p, acc, v;
    p = PP[dut];
    acc = md ? 0 : fr[r0][c0][ch];
    for (int i = 0; i < p; i++)
      for (int j = 0; j < p; j++) begin
        v = fr[r0+i][c0+j][ch];
        if (md) acc += v;
        else if (v > acc) acc = v;
      end
    if (md) acc = acc >>> (2 * $clog2(p));
    return sx(acc, WW[dut]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int dut, input bit v, input bit md, input int r, input int c, input bit junk);
    int x;
    val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      x = junk ? int'($urandom) : fr[r][c][ch];
      case (dut)
        0:       pix_a[ch*16 +: 16] = 16'(x);
        1:       if (ch == 0) pix_b = 16'(x);
        default: if (ch < 2) pix_c[ch*8 +: 8] = 8'(x);
      endcase
    end
    case (dut)
      0:       begin val_a = v; mode_a = md; end
      1:       begin val_b = v; mode_b = md; end
      default: begin val_c = v; mode_c = md; end
    endcase
  endtask

  task automatic sample(input int dut);
    for (int ch = 0; ch < 4; ch++) obs_d[ch] = 0;
    case (dut)
      0: begin
        obs_v = int'(ov_a); obs_fd = int'(fd_a);
        for (int ch = 0; ch < 4; ch++) obs_d[ch] = sx(int'(dout_a[ch*16 +: 16]), 16);
      end
      1: begin
        obs_v = int'(ov_b); obs_fd = int'(fd_b);
        obs_d[0] = sx(int'(dout_b), 16);
      end
      default: begin
        obs_v = int'(ov_c); obs_fd = int'(fd_c);
        for (int ch = 0; ch < 2; ch++) obs_d[ch] = sx(int'(dout_c[ch*8 +: 8]), 8);
      end
    endcase
  endtask

  // Send up to npix pixels of fr[] in raster order with random gaps of gap_pct.
  task automatic run_frame(input int dut, input bit md, input int gap_pct, input int npix);
    int p, wcn, wrn, sent, ng;
    bit ev, efd;
    p = PP[dut]; wcn = NC[dut] / p; wrn = NR[dut] / p; sent = 0;
    for (int r = 0; r < NR[dut]; r++) begin
      for (int c = 0; c < NC[dut]; c++) begin
        if (sent >= npix) return;
        ng = 0;
        while (ng < 8 && int'($urandom_range(99)) < gap_pct) begin
          drive(dut, 1'b0, 1'($urandom_range(1)), 0, 0, 1'b1);
          @(posedge clk); #1;
          sample(dut);
          chk("gap_out_valid", obs_v, 0);
          chk("gap_frame_done", obs_fd, 0);
          for (int ch = 0; ch < NCH[dut]; ch++) chk("gap_data_hold", obs_d[ch], last_d[dut][ch]);
          ng++;
        end
        drive(dut, 1'b1, (r == 0 && c == 0) ? md : 1'($urandom_range(1)), r, c, 1'b0);
        @(posedge clk); #1;
        sent++;
        sample(dut);
        ev  = (c % p == p - 1) && (r % p == p - 1) && (c < wcn * p) && (r < wrn * p);
        efd = ev && (c == wcn * p - 1) && (r == wrn * p - 1);
        chk("out_valid", obs_v, int'(ev));
        chk("frame_done", obs_fd, int'(efd));
        for (int ch = 0; ch < NCH[dut]; ch++) begin
          if (ev) last_d[dut][ch] = win_exp(dut, r - (p - 1), c - (p - 1), ch, md);
          chk(ev ? "data_out" : "data_hold", obs_d[ch], last_d[dut][ch]);
        end
      end
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int ch = 0; ch < 4; ch++)
          fr[r][c][ch] = (ch == 0) ? (r * 4 + c) : -(r * 4 + c);
  endtask

  task automatic fill_rand(input int w);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        for (int ch = 0; ch < 4; ch++)
          fr[r][c][ch] = sx(int'($urandom), w);
  endtask

  task automatic check_zero(input int dut, input string tag);
    sample(dut);
    chk({tag, "_out_valid"}, obs_v, 0);
    chk({tag, "_frame_done"}, obs_fd, 0);
    for (int ch = 0; ch < NCH[dut]; ch++) chk({tag, "_data"}, obs_d[ch], 0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) for (int ch = 0; ch < 4; ch++) last_d[d][ch] = 0;
    rst_n = 1'b0;
    mode_a = 1'b0; mode_b = 1'b0; mode_c = 1'b0;
    pix_a = '0; pix_b = '0; pix_c = '0;
    val_a = 1'b0; val_b = 1'b0; val_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_zero(d, "reset");
    @(negedge clk) rst_n = 1'b1;

    // Max, ramp: ch0 5,7,13,15; negated channels 0,-2,-8,-10
    fill_ramp();
    run_frame(0, 1'b0, 0, 1000);

    // Average with negative top-left window (-10 >>> 2 = -3), rest 4
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) for (int ch = 0; ch < 4; ch++)
      fr[r][c][ch] = 4;
    for (int ch = 0; ch < 4; ch++) begin
      fr[0][0][ch] = -1; fr[0][1][ch] = -2; fr[1][0][ch] = -3; fr[1][1][ch] = -4;
    end
    run_frame(0, 1'b1, 0, 1000);

    // Ramp again with ~50% in_valid gaps
    fill_ramp();
    run_frame(0, 1'b0, 50, 1000);

    // 5x5: last column/row carry large values that must never appear
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++)
      fr[r][c][0] = (r == 4 || c == 4) ? 30000 : (r * 5 + c);
    run_frame(1, 1'b0, 0, 1000);
    run_frame(1, 1'b1, 20, 1000);

    // Reset after 6 pixels, then a clean frame
    fill_ramp();
    run_frame(0, 1'b0, 0, 6);
    drive(0, 1'b0, 1'b1, 0, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero(0, "async_reset");
    repeat (2) begin
      @(posedge clk); #1;
      check_zero(0, "in_reset");
    end
    for (int d = 0; d < 3; d++) for (int ch = 0; ch < 4; ch++) last_d[d][ch] = 0;
    @(negedge clk) rst_n = 1'b1;
    run_frame(0, 1'b0, 0, 1000);

    // Random frames, back to back, random modes and gaps
    for (int k = 0; k < 6; k++) begin
      fill_rand(16);
      run_frame(0, 1'($urandom_range(1)), (k % 2) * 30, 1000);
    end
    for (int k = 0; k < 3; k++) begin
      fill_rand(16);
      run_frame(1, 1'($urandom_range(1)), 25, 1000);
    end
    for (int k = 0; k < 6; k++) begin
      fill_rand(8);
      run_frame(2, 1'(k % 2), (k / 2) * 20, 1000);
    end

    drive(0, 1'b0, 1'b0, 0, 0, 1'b1);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
- Streaming 2D pooling unit for the CNN datapath. Takes raster-scan feature-map pixels, one pixel per cycle across CH parallel channels.
- Emits one pooled value per channel for every non-overlapping POOL x POOL window (stride = POOL).
- Run-time selectable max or average mode.
- A per-column partial-result line buffer lets in_valid gaps occur anywhere in a frame without losing window state.

Parameters:
- dataColNum, 28: input image width in pixels.
- dataRowNum, 28: input image height in pixels.
- wordlength, 16: signed pixel width.
- CH, 4: number of channels processed in parallel.
- POOL, 2: window edge and stride. Must be a power of two, >= 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- irst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pixels_in valid this cycle; a pixel is accepted on every cycle it is high.
- mode  input  1  0 = max, 1 = average. Sampled only on the first pixel of a frame (row 0, col 0).
- pixels_in  input  CH*wordlength  signed pixels; channel c occupies bits [c*wordlength +: wordlength].
- data_out  output  CH*wordlength  pooled signed results, same packing as pixels_in.
- out_valid  output  1  data_out valid (one-cycle pulse per window).
- frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

Behaviour:
- Reset (irst_n low, asynchronous): the following clear to 0:
  - col/row counters
  - horizontal accumulators
  - mode register
  - data_out, out_valid, frame_done
  - Line buffer contents need not be cleared; they are always written before being read.
- Counters:
  - col counts 0..dataColNum-1 on each accepted pixel.
  - At dataColNum-1, col wraps to 0 and row increments.
  - At row dataRowNum-1, col dataColNum-1, both wrap to 0 (next frame).
- in_valid low: hold all state (no reset of window, unlike the previous pooling block). out_valid and frame_done go low.
- Window position: wc = col / POOL, wr = row / POOL, intra-window offsets col % POOL and row % POOL.
- Partial windows are ignored, not output:
  - Columns with col >= POOL*floor(dataColNum/POOL).
  - Rows with row >= POOL*floor(dataRowNum/POOL).
- Combine operation f(a,b):
  - Max mode: signed maximum.
  - Average mode: signed sum in ACC width = wordlength + 2*log2(POOL), sign-extended.
- Horizontal accumulator (per channel):
  - Loaded with the pixel at col%POOL == 0.
  - Combined with the pixel for the other offsets.
- Line buffer: floor(dataColNum/POOL) entries x CH x ACC bits, indexed by wc. At col%POOL == POOL-1, h = f(horizontal acc, current pixel):
  - row%POOL == 0: lb[wc] <= h.
  - 0 < row%POOL < POOL-1: lb[wc] <= f(lb[wc], h).
  - row%POOL == POOL-1: result = f(lb[wc], h); data_out registered; out_valid = 1 on the next cycle.
- Output formatting:
  - Max result: truncated to wordlength (lossless).
  - Average result: sum >>> 2*log2(POOL) (arithmetic shift, rounds toward -inf), then low wordlength bits.
- Latency: exactly 1 cycle from acceptance of a window's last pixel to out_valid. Throughput: one pixel per channel per cycle.
- frame_done: asserted with out_valid for the window at wr = floor(dataRowNum/POOL)-1, wc = floor(dataColNum/POOL)-1.
- data_out holds its last value while out_valid is low.
- Mode: mode changes mid-frame are ignored. The registered mode applies to the whole frame.
- Reset mid-frame: the next accepted pixel is treated as row 0, col 0 of a new frame. No stale output is produced.
- Simultaneous events: a frame's last pixel and the next frame's first pixel on consecutive cycles must work with no bubble. The next frame's first pixel may be accepted on the same cycle out_valid/frame_done is high.

Test Plan:
1. Max, POOL=2, CH=1, 4x4 frame with values 0..15 raster, in_valid continuously high -> out_valid pulses carrying 5, 7, 13, 15. frame_done coincides with 15. Each pulse 1 cycle after pixels 5, 7, 13, 15 are accepted.
2. Average, POOL=2, 4x4 frame with window {-1,-2,-3,-4} at top-left and the rest 4 -> first output -3 (sum -10 >>> 2 = -3), others 4.
3. Max, CH=4, channel c pixel = (c ? -row*4-col : row*4+col) -> channel 0 gives 5, 7, 13, 15; channels 1..3 give 0, -2, -8, -10.
4. Test 1 stimulus with in_valid randomly deasserted (~50%) -> identical output sequence. out_valid never asserted during gaps.
5. dataColNum=5, dataRowNum=5, POOL=2, max -> exactly 4 outputs; column 4 and row 4 pixels never influence results.
6. Assert irst_n low after 6 pixels, then send a full frame -> all outputs zero during reset. Post-reset outputs match test 1 exactly. mode toggled mid-frame has no effect.
